// File: rtl/mat_mult_engine.sv
// Matrix-multiply engine: computes C = A x B one C row at a time, reading A rows and
// transposed B columns from the matrix memories and writing each finished C row as one word.
module mat_mult_engine #(
  parameter int N       = 6,
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 2*WIDTH+N-1,
  parameter int ADDR    = 12
) (
  input  logic                 clk_MAT,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR-1:0]      a_base,
  input  logic [ADDR-1:0]      b_base,
  input  logic [ADDR-1:0]      c_base,
  output logic                 busy,
  output logic                 done,
  output logic                 A_MAT_rd,
  output logic [ADDR-1:0]      A_MAT_addr,
  input  logic [N*WIDTH-1:0]   A_MAT_dout,
  output logic                 B_MAT_rd,
  output logic [ADDR-1:0]      B_MAT_addr,
  input  logic [N*WIDTH-1:0]   B_MAT_dout,
  output logic                 C_MAT_wr,
  output logic [ADDR-1:0]      C_MAT_addr,
  output logic [N*M_WIDTH-1:0] C_MAT_din
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(N-1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LATCH_A,
    MAC,
    WRITE_C,
    FIN
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        rowCnt_q, rowCnt_d;
  logic [CW-1:0]        colCnt_q, colCnt_d;
  logic [ADDR-1:0]      aBase_q, aBase_d;
  logic [ADDR-1:0]      bBase_q, bBase_d;
  logic [ADDR-1:0]      cBase_q, cBase_d;
  logic [N*WIDTH-1:0]   aRow_q, aRow_d;
  logic [N*M_WIDTH-1:0] cRow_q, cRow_d;

  logic signed [M_WIDTH-1:0] dotSum;
  logic signed [PW-1:0]      aElem, bElem, prod;

  // Dot product of the held A row with the B column currently on the read port;
  // operands are sign-extended first so every product is exact before accumulation.
  always_comb begin
    dotSum = '0;
    aElem  = '0;
    bElem  = '0;
    prod   = '0;
    for (int m = 0; m < N; m++) begin
      aElem  = {{WIDTH{aRow_q[m*WIDTH+WIDTH-1]}}, aRow_q[m*WIDTH +: WIDTH]};
      bElem  = {{WIDTH{B_MAT_dout[m*WIDTH+WIDTH-1]}}, B_MAT_dout[m*WIDTH +: WIDTH]};
      prod   = aElem * bElem;
      dotSum = dotSum + {{(M_WIDTH-PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk_MAT or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rowCnt_q <= '0;
      colCnt_q <= '0;
      aBase_q  <= '0;
      bBase_q  <= '0;
      cBase_q  <= '0;
      aRow_q   <= '0;
      cRow_q   <= '0;
    end else begin
      state_q  <= state_d;
      rowCnt_q <= rowCnt_d;
      colCnt_q <= colCnt_d;
      aBase_q  <= aBase_d;
      bBase_q  <= bBase_d;
      cBase_q  <= cBase_d;
      aRow_q   <= aRow_d;
      cRow_q   <= cRow_d;
    end
  end

  // Strobes, addresses and data are decoded from the state register, so an async
  // reset forces every output to zero immediately.
  always_comb begin
    state_d    = state_q;
    rowCnt_d   = rowCnt_q;
    colCnt_d   = colCnt_q;
    aBase_d    = aBase_q;
    bBase_d    = bBase_q;
    cBase_d    = cBase_q;
    aRow_d     = aRow_q;
    cRow_d     = cRow_q;
    busy       = 1'b0;
    done       = 1'b0;
    A_MAT_rd   = 1'b0;
    A_MAT_addr = '0;
    B_MAT_rd   = 1'b0;
    B_MAT_addr = '0;
    C_MAT_wr   = 1'b0;
    C_MAT_addr = '0;
    C_MAT_din  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          aBase_d  = a_base;
          bBase_d  = b_base;
          cBase_d  = c_base;
          rowCnt_d = '0;
          state_d  = LOAD_A;
        end
      end
      LOAD_A: begin
        busy       = 1'b1;
        A_MAT_rd   = 1'b1;
        A_MAT_addr = aBase_q + ADDR'(rowCnt_q);
        state_d    = LATCH_A;
      end
      LATCH_A: begin
        busy       = 1'b1;
        aRow_d     = A_MAT_dout;
        B_MAT_rd   = 1'b1;
        B_MAT_addr = bBase_q;
        colCnt_d   = '0;
        state_d    = MAC;
      end
      MAC: begin
        busy = 1'b1;
        cRow_d[int'(colCnt_q)*M_WIDTH +: M_WIDTH] = dotSum;
        // Prefetch the next column so it arrives exactly when the next MAC cycle needs it.
        if (colCnt_q == LAST_IDX) begin
          state_d = WRITE_C;
        end else begin
          B_MAT_rd   = 1'b1;
          B_MAT_addr = bBase_q + ADDR'(colCnt_q) + ADDR'(1);
          colCnt_d   = colCnt_q + CW'(1);
        end
      end
      WRITE_C: begin
        busy       = 1'b1;
        C_MAT_wr   = 1'b1;
        C_MAT_addr = cBase_q + ADDR'(rowCnt_q);
        C_MAT_din  = cRow_q;
        if (rowCnt_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          rowCnt_d = rowCnt_q + CW'(1);
          state_d  = LOAD_A;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
